// File: rtl/dcache_pkg.sv
// Shared definitions for the data-cache writeback path: geometry of a cache
// line, the writeback FSM state encoding and the AXI constants it drives.
// The optional retry-on-error behaviour is selected by DCACHE_WB_RETRY_EN.
package dcache_pkg;

    // Cache geometry
    localparam int INDEX_SIZE    = 6;
    localparam int WORD_OFF_SIZE = 4;
    localparam int TAG_SIZE      = 20;
    localparam int WORD_W        = 32;
    localparam int WORDS         = 2 ** WORD_OFF_SIZE;
    localparam int DATA_W        = WORD_W * WORDS;
    localparam int LINE_W        = TAG_SIZE + DATA_W;

    // Field offsets inside a line read from the RAM: words low, tag high
    localparam int DATA_LSB      = 0;
    localparam int TAG_LSB       = DATA_W;

    // Bits of a byte address below the index (byte-in-line offset)
    localparam int LINE_OFF_BITS = 32 - TAG_SIZE - INDEX_SIZE;

    // AXI constants used by the write burst
    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'd2;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [7:0] BURST_LEN  = 8'(WORDS - 1);
    localparam logic [3:0] STRB_ALL   = 4'hF;

    // Number of extra attempts after an error response (retry build only)
    localparam logic [1:0] RETRY_MAX  = 2'd3;

    typedef enum logic [2:0] {
        WB_IDLE  = 3'd0,
        WB_CHECK = 3'd1,
        WB_AW    = 3'd2,
        WB_W     = 3'd3,
        WB_B     = 3'd4,
        WB_CLEAN = 3'd5,
        WB_DONE  = 3'd6
    } wb_state_e;

    // Byte address of the first word of a line
    function automatic logic [31:0] line_addr(input logic [TAG_SIZE-1:0]   tag,
                                              input logic [INDEX_SIZE-1:0] idx);
        return {tag, idx, {LINE_OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/dcache_wb_beat_mux.sv
// Line buffer for the writeback path. Captures a whole cache line when the
// eviction is accepted and walks a beat counter across its 16 data words,
// presenting the current word as write data. The counter wraps to 0 after
// the last beat so a restarted burst begins again at word 0.
module dcache_wb_beat_mux
    import dcache_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [LINE_W-1:0]        line_in,
    input  logic                     beat_ack,
    output logic [WORD_OFF_SIZE-1:0] beat_cnt,
    output logic                     beat_last,
    output logic [WORD_W-1:0]        wdata,
    output logic [TAG_SIZE-1:0]      tag
);

    logic [DATA_W-1:0]   data_q;
    logic [TAG_SIZE-1:0] tag_q;

    // Line capture: contents are don't-care until the first load, so no reset
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= line_in[DATA_LSB +: DATA_W];
            tag_q  <= line_in[TAG_LSB +: TAG_SIZE];
        end
    end

    // Beat counter: cleared on a new line, advanced by each accepted beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt <= '0;
        end else if (load) begin
            beat_cnt <= '0;
        end else if (beat_ack) begin
            beat_cnt <= beat_cnt + WORD_OFF_SIZE'(1);
        end
    end

    assign beat_last = (beat_cnt == {WORD_OFF_SIZE{1'b1}});
    assign wdata     = data_q[{beat_cnt, 5'd0} +: WORD_W];
    assign tag       = tag_q;

endmodule

// File: rtl/dcache_writeback.sv
// Data-cache eviction writer. On a request it snapshots one line and its
// valid/dirty bits; a valid dirty line is written out as a single 16-beat
// AXI INCR burst and then marked clean. Clean or invalid lines finish two
// cycles after the request with no bus traffic.
//
// Handshakes: every AXI channel transfers on a cycle where both valid and
// ready are high at the rising edge; once raised, valid and its payload stay
// stable until that transfer, and wvalid stays high for the whole burst.
//
// Build option DCACHE_WB_RETRY_EN: an error write response restarts the burst
// from the address phase, up to three times, before the error is reported.
// Without it the first error response ends the eviction with wb_err set.
module dcache_writeback
    import dcache_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,

    // Controller side
    input  logic                  wb_req,
    input  logic [INDEX_SIZE-1:0] wb_index,
    output logic                  wb_busy,
    output logic                  wb_done,
    output logic                  wb_err,

    // Line RAM read port (combinational read)
    output logic [INDEX_SIZE-1:0] ram_raddr,
    input  logic [LINE_W-1:0]     ram_rdata,
    input  logic                  ram_valid,
    input  logic                  ram_dirty,

    // Valid/dirty bit write port
    output logic                  dv_wen,
    output logic [INDEX_SIZE-1:0] dv_waddr,
    output logic                  dv_w_valid,
    output logic                  dv_w_dirty,

    // AXI write address channel
    output logic [31:0]           awaddr,
    output logic [7:0]            awlen,
    output logic [2:0]            awsize,
    output logic [1:0]            awburst,
    output logic                  awvalid,
    input  logic                  awready,

    // AXI write data channel
    output logic [31:0]           wdata,
    output logic [3:0]            wstrb,
    output logic                  wlast,
    output logic                  wvalid,
    input  logic                  wready,

    // AXI write response channel
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    // Current FSM state, for observation only
    output wb_state_e             dbg_state
);

    wb_state_e             state;
    wb_state_e             state_nxt;

    logic [INDEX_SIZE-1:0] idx_q;
    logic                  valid_q;
    logic                  dirty_q;
    logic                  err_q;
    logic [31:0]           awaddr_q;

    logic                  req_acc;
    logic                  beat_ack;
    logic                  resp_ok;
    logic                  resp_err;
    logic                  out_of_retries;

    logic [WORD_OFF_SIZE-1:0] beat_cnt;
    logic                     beat_last;
    logic [TAG_SIZE-1:0]      buf_tag;

    assign req_acc  = (state == WB_IDLE) && wb_req;
    assign beat_ack = wvalid && wready;
    assign resp_ok  = (state == WB_B) && bvalid && (bresp == RESP_OKAY);
    assign resp_err = (state == WB_B) && bvalid && (bresp != RESP_OKAY);

`ifdef DCACHE_WB_RETRY_EN
    logic [1:0] retry_q;

    // Retry count for the current eviction; bumped on each retried error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_q <= '0;
        end else if (req_acc) begin
            retry_q <= '0;
        end else if (resp_err && (retry_q != RETRY_MAX)) begin
            retry_q <= retry_q + 2'd1;
        end
    end

    assign out_of_retries = (retry_q == RETRY_MAX);
`else
    assign out_of_retries = 1'b1;
`endif

    // Line buffer and beat sequencing
    dcache_wb_beat_mux u_beat_mux (
        .clk       (clk),
        .reset     (reset),
        .load      (req_acc),
        .line_in   (ram_rdata),
        .beat_ack  (beat_ack),
        .beat_cnt  (beat_cnt),
        .beat_last (beat_last),
        .wdata     (wdata),
        .tag       (buf_tag)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= WB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            WB_IDLE: begin
                if (wb_req) begin
                    state_nxt = WB_CHECK;
                end
            end
            WB_CHECK: begin
                if (valid_q && dirty_q) begin
                    state_nxt = WB_AW;
                end else begin
                    state_nxt = WB_DONE;
                end
            end
            WB_AW: begin
                if (awready) begin
                    state_nxt = WB_W;
                end
            end
            WB_W: begin
                if (wready && beat_last) begin
                    state_nxt = WB_B;
                end
            end
            WB_B: begin
                if (resp_ok) begin
                    state_nxt = WB_CLEAN;
                end else if (resp_err) begin
                    state_nxt = out_of_retries ? WB_DONE : WB_AW;
                end
            end
            WB_CLEAN: state_nxt = WB_DONE;
            WB_DONE:  state_nxt = WB_IDLE;
            default:  state_nxt = WB_IDLE;
        endcase
    end

    // Snapshot of index and status bits taken when the request is accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
        end else if (req_acc) begin
            idx_q   <= wb_index;
            valid_q <= ram_valid;
            dirty_q <= ram_dirty;
        end
    end

    // Burst address, formed once from the buffered tag and held for retries
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            awaddr_q <= '0;
        end else if (state == WB_CHECK) begin
            awaddr_q <= line_addr(buf_tag, idx_q);
        end
    end

    // Sticky error: cleared by a new request, set when the line gives up
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (req_acc) begin
            err_q <= 1'b0;
        end else if (resp_err && out_of_retries) begin
            err_q <= 1'b1;
        end
    end

    // Outputs decoded from the registered state
    assign wb_busy    = (state != WB_IDLE);
    assign wb_done    = (state == WB_DONE);
    assign wb_err     = err_q;

    assign ram_raddr  = (state == WB_IDLE) ? wb_index : idx_q;

    assign dv_wen     = (state == WB_CLEAN);
    assign dv_waddr   = idx_q;
    assign dv_w_valid = 1'b1;
    assign dv_w_dirty = 1'b0;

    assign awaddr     = awaddr_q;
    assign awlen      = BURST_LEN;
    assign awsize     = SIZE_4B;
    assign awburst    = BURST_INCR;
    assign awvalid    = (state == WB_AW);

    assign wstrb      = STRB_ALL;
    assign wvalid     = (state == WB_W);
    assign wlast      = wvalid && beat_last;

    assign bready     = (state == WB_B);

    assign dbg_state  = state;

endmodule

// File: tb/tb_dcache_writeback.sv
// Testbench for dcache_writeback: line RAM and AXI slave models, a reference
// model that predicts every bus transfer per eviction, and a monitor that
// pops and compares expectations as the DUT produces outputs.
module tb_dcache_writeback;
    import dcache_pkg::*;

    localparam int NLINES = 2 ** INDEX_SIZE;

    logic                  clk;
    logic                  reset;
    logic                  wb_req;
    logic [INDEX_SIZE-1:0] wb_index;
    logic                  wb_busy, wb_done, wb_err;
    logic [INDEX_SIZE-1:0] ram_raddr;
    logic [LINE_W-1:0]     ram_rdata;
    logic                  ram_valid, ram_dirty;
    logic                  dv_wen;
    logic [INDEX_SIZE-1:0] dv_waddr;
    logic                  dv_w_valid, dv_w_dirty;
    logic [31:0]           awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awvalid, awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wlast, wvalid, wready;
    logic [1:0]            bresp;
    logic                  bvalid, bready;
    wb_state_e             dbg_state;

    dcache_writeback dut (
        .clk        (clk),
        .reset      (reset),
        .wb_req     (wb_req),
        .wb_index   (wb_index),
        .wb_busy    (wb_busy),
        .wb_done    (wb_done),
        .wb_err     (wb_err),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .ram_valid  (ram_valid),
        .ram_dirty  (ram_dirty),
        .dv_wen     (dv_wen),
        .dv_waddr   (dv_waddr),
        .dv_w_valid (dv_w_valid),
        .dv_w_dirty (dv_w_dirty),
        .awaddr     (awaddr),
        .awlen      (awlen),
        .awsize     (awsize),
        .awburst    (awburst),
        .awvalid    (awvalid),
        .awready    (awready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .wvalid     (wvalid),
        .wready     (wready),
        .bresp      (bresp),
        .bvalid     (bvalid),
        .bready     (bready),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- line RAM model ----------------
    logic [TAG_SIZE-1:0] mem_tag   [NLINES];
    logic [31:0]         mem_word  [NLINES][WORDS];
    logic                mem_valid [NLINES];
    logic                mem_dirty [NLINES];

    always_comb begin
        ram_rdata = '0;
        for (int i = 0; i < WORDS; i++) ram_rdata[32*i +: 32] = mem_word[ram_raddr][i];
        ram_rdata[TAG_LSB +: TAG_SIZE] = mem_tag[ram_raddr];
    end
    assign ram_valid = mem_valid[ram_raddr];
    assign ram_dirty = mem_dirty[ram_raddr];

    // ---------------- reference model state and scoreboard ----------------
    logic        ref_valid [NLINES];
    logic        ref_dirty [NLINES];

    logic [31:0]           exp_aw_q  [$];
    logic [32:0]           exp_w_q   [$];   // {wlast, wdata}
    logic [INDEX_SIZE-1:0] exp_dv_q  [$];
    logic                  exp_err_q [$];
    int                    exp_lat_q [$];   // 0 = latency not checked
    logic [1:0]            resp_q    [$];   // responses the slave will give

    int n_cmp, n_bad;
    int done_cnt, dv_cnt, aw_cnt;
    int bp_mode;                            // 0 always ready, 1 fixed pattern, 2 random

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %0h with nothing expected", name, act);
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        logic w_fin, b_fin, b_pend;
        int   aw_wait;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        b_pend = 1'b0; aw_wait = 0;
        forever begin
            @(negedge clk);
            w_fin   = !reset && wvalid && wready && wlast;
            b_fin   = !reset && bvalid && bready;
            aw_wait = (!reset && awvalid && !awready) ? aw_wait + 1 : 0;
            @(posedge clk);
            #1;
            if (reset) begin
                awready = 1'b0; wready = 1'b0; bvalid = 1'b0; b_pend = 1'b0; aw_wait = 0;
            end else begin
                if (b_fin) bvalid = 1'b0;
                if (w_fin) b_pend = 1'b1;
                if (b_pend && !bvalid && (bp_mode == 0 || $urandom_range(0, 1) == 1)) begin
                    bvalid = 1'b1;
                    bresp  = (resp_q.size() > 0) ? resp_q.pop_front() : RESP_OKAY;
                    b_pend = 1'b0;
                end
                case (bp_mode)
                    0: begin awready = 1'b1; wready = 1'b1; end
                    1: begin awready = (aw_wait >= 3); wready = !wready; end
                    default: begin
                        awready = ($urandom_range(0, 2) != 0);
                        wready  = ($urandom_range(0, 3) != 0);
                    end
                endcase
            end
        end
    end

    // ---------------- monitor ----------------
    int cyc;
    initial begin
        logic        aw_hold, w_hold, w_pend;
        logic [31:0] aw_prev, w_prev;
        logic        wl_prev;
        int          req_cyc;
        logic [31:0] ea;
        logic [32:0] ew;
        int          el;
        aw_hold = 1'b0; w_hold = 1'b0; w_pend = 1'b0; req_cyc = 0; cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                aw_hold = 1'b0; w_hold = 1'b0; w_pend = 1'b0;
            end else begin
                if (wb_req && !wb_busy) req_cyc = cyc;

                if (aw_hold) check("aw_stable", 64'({awvalid, awaddr}), 64'({1'b1, aw_prev}));
                if (awvalid && awready) begin
                    aw_cnt++;
                    if (exp_aw_q.size() == 0) unexpected("aw_extra", 64'(awaddr));
                    else begin
                        ea = exp_aw_q.pop_front();
                        check("awaddr", 64'(awaddr), 64'(ea));
                    end
                    check("aw_ctrl", 64'({awlen, awsize, awburst}), 64'({8'd15, 3'd2, 2'b01}));
                end
                aw_hold = awvalid && !awready;
                aw_prev = awaddr;

                if (w_pend) check("w_continuous", 64'(wvalid), 64'(1));
                if (w_hold) check("w_stable", 64'({wlast, wdata}), 64'({wl_prev, w_prev}));
                if (wvalid && wready) begin
                    if (exp_w_q.size() == 0) unexpected("w_extra", 64'(wdata));
                    else begin
                        ew = exp_w_q.pop_front();
                        check("wbeat", 64'({wlast, wdata}), 64'(ew));
                    end
                    check("wstrb", 64'(wstrb), 64'(4'hF));
                end
                w_hold  = wvalid && !wready;
                w_pend  = wvalid && !(wready && wlast);
                w_prev  = wdata;
                wl_prev = wlast;

                if (dv_wen) begin
                    dv_cnt++;
                    if (exp_dv_q.size() == 0) unexpected("dv_extra", 64'(dv_waddr));
                    else check("dv_write", 64'({dv_waddr, dv_w_valid, dv_w_dirty}),
                               64'({exp_dv_q.pop_front(), 1'b1, 1'b0}));
                end

                if (wb_done) begin
                    done_cnt++;
                    if (exp_err_q.size() == 0) unexpected("done_extra", 64'(wb_err));
                    else begin
                        check("done_err", 64'(wb_err), 64'(exp_err_q.pop_front()));
                        el = exp_lat_q.pop_front();
                        if (el != 0) check("done_latency", 64'(cyc - req_cyc), 64'(el));
                    end
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic fill_line(input int idx, input logic [TAG_SIZE-1:0] tag,
                             input logic v, input logic d);
        mem_tag[idx] = tag;
        for (int w = 0; w < WORDS; w++) mem_word[idx][w] = $urandom();
        mem_valid[idx] = v;  mem_dirty[idx] = d;
        ref_valid[idx] = v;  ref_dirty[idx] = d;
    endtask

    // Predict the whole eviction, queue the expectations, then pulse wb_req
    task automatic issue(input int idx, input int n_err, input logic [1:0] ecode);
        int          attempts;
        logic        fail_all;
        logic [31:0] a;
        if (ref_valid[idx] && ref_dirty[idx]) begin
`ifdef DCACHE_WB_RETRY_EN
            attempts = (n_err > 3) ? 4 : n_err + 1;
            fail_all = (n_err > 3);
`else
            attempts = 1;
            fail_all = (n_err > 0);
`endif
            a = 32'(mem_tag[idx]) * 32'd4096 + 32'(idx) * 32'd64;
            for (int k = 0; k < attempts; k++) begin
                exp_aw_q.push_back(a);
                for (int b = 0; b < WORDS; b++) exp_w_q.push_back({b == WORDS - 1, mem_word[idx][b]});
                resp_q.push_back((k < n_err) ? ecode : 2'b00);
            end
            if (!fail_all) begin
                exp_dv_q.push_back(INDEX_SIZE'(idx));
                ref_dirty[idx] = 1'b0;
            end
            exp_err_q.push_back(fail_all);
            exp_lat_q.push_back(0);
        end else begin
            exp_err_q.push_back(1'b0);
            exp_lat_q.push_back(2);
        end
        @(posedge clk); #1;
        wb_req = 1'b1; wb_index = INDEX_SIZE'(idx);
        @(posedge clk); #1;
        wb_req = 1'b0;
    endtask

    task automatic wait_done(input int d0, input string name);
        int t;
        t = 0;
        while (done_cnt == d0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt == d0) begin
            n_cmp++; n_bad++;
            $display("FAIL %s_timeout: got no wb_done, required one within 3000 cycles", name);
        end
        @(negedge clk);
        check({name, "_idle_after"}, 64'({wb_busy, wb_done}), 64'(0));
    endtask

    // Full eviction; a dirty-bit write seen on the port is applied to the RAM
    task automatic run(input int idx, input int n_err, input logic [1:0] ecode, input string name);
        int d0, v0;
        d0 = done_cnt; v0 = dv_cnt;
        issue(idx, n_err, ecode);
        wait_done(d0, name);
        if (dv_cnt != v0) mem_dirty[idx] = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int a0, d0, v0, beats, t, idx, nerr;
        logic exp_fail;
        n_cmp = 0; n_bad = 0; done_cnt = 0; dv_cnt = 0; aw_cnt = 0; bp_mode = 0;
        wb_req = 1'b0; wb_index = '0;
        for (int i = 0; i < NLINES; i++) fill_line(i, TAG_SIZE'($urandom()), 1'b0, 1'b0);

        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({wb_busy, wb_done, wb_err, awvalid, wvalid, wlast, bready, dv_wen}), 64'(0));
        check("reset_state", 64'(dbg_state), 64'(WB_IDLE));
        @(negedge clk);
        reset = 1'b0;

        // Dirty line with known contents, no backpressure
        fill_line(5, 20'hABCDE, 1'b1, 1'b1);
        for (int w = 0; w < WORDS; w++) mem_word[5][w] = 32'h1000_0000 + 32'(w);
        check("awaddr_ref", 64'(32'(mem_tag[5]) * 32'd4096 + 32'd5 * 32'd64), 64'(32'hABCDE140));
        run(5, 0, 2'b00, "dirty");

        // Clean line: no bus traffic, done two cycles after request
        fill_line(9, TAG_SIZE'($urandom()), 1'b1, 1'b0);
        a0 = aw_cnt; v0 = dv_cnt;
        run(9, 0, 2'b00, "clean");
        check("clean_no_aw", 64'(aw_cnt - a0), 64'(0));
        check("clean_no_dv", 64'(dv_cnt - v0), 64'(0));

        // Invalid line
        fill_line(10, TAG_SIZE'($urandom()), 1'b0, 1'b1);
        run(10, 0, 2'b00, "invalid");

        // Backpressure: awready after 3 cycles, wready toggling
        bp_mode = 1;
        fill_line(12, TAG_SIZE'($urandom()), 1'b1, 1'b1);
        run(12, 0, 2'b00, "backpressure");
        bp_mode = 0;

        // Error response: two SLVERR then OKAY
        fill_line(20, TAG_SIZE'($urandom()), 1'b1, 1'b1);
        a0 = aw_cnt;
`ifdef DCACHE_WB_RETRY_EN
        exp_fail = 1'b0;
        run(20, 2, 2'b10, "error");
        check("error_aw_bursts", 64'(aw_cnt - a0), 64'(3));
`else
        exp_fail = 1'b1;
        run(20, 2, 2'b10, "error");
        check("error_aw_bursts", 64'(aw_cnt - a0), 64'(1));
`endif
        repeat (3) @(negedge clk);
        check("error_sticky", 64'(wb_err), 64'(exp_fail));
        resp_q.delete();

        // Asynchronous reset during beat 7
        fill_line(30, TAG_SIZE'($urandom()), 1'b1, 1'b1);
        v0 = dv_cnt;
        issue(30, 0, 2'b00);
        beats = 0; t = 0;
        while (beats < 7 && t < 500) begin
            @(negedge clk);
            if (wvalid && wready) beats++;
            t++;
        end
        @(negedge clk);
        check("rst_at_beat7", 64'({wvalid, wdata}), 64'({1'b1, mem_word[30][7]}));
        #2;
        reset = 1'b1;
        #1;
        check("rst_abort", 64'({awvalid, wvalid, wlast, bready, dv_wen, wb_busy, wb_done}), 64'(0));
        exp_aw_q.delete(); exp_w_q.delete(); exp_dv_q.delete();
        exp_err_q.delete(); exp_lat_q.delete(); resp_q.delete();
        ref_dirty[30] = 1'b1;   // aborted eviction leaves the line dirty
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_no_dv", 64'(dv_cnt - v0), 64'(0));
        run(30, 0, 2'b00, "after_reset");

        // Request while busy is ignored
        bp_mode = 2;
        fill_line(40, TAG_SIZE'($urandom()), 1'b1, 1'b1);
        fill_line(41, TAG_SIZE'($urandom()), 1'b1, 1'b1);
        a0 = aw_cnt; d0 = done_cnt; v0 = dv_cnt;
        issue(40, 0, 2'b00);
        repeat (4) @(posedge clk);
        #1;
        wb_req = 1'b1; wb_index = 6'd41;
        @(posedge clk); #1;
        wb_req = 1'b0;
        wait_done(d0, "busy");
        if (dv_cnt != v0) mem_dirty[40] = 1'b0;
        repeat (40) @(negedge clk);
        check("busy_one_burst", 64'(aw_cnt - a0), 64'(1));
        check("busy_one_done", 64'(done_cnt - d0), 64'(1));

        // Line 5 was written back, so it is now clean; error flag clears
        run(5, 0, 2'b00, "rewrite_clean");
        check("err_cleared", 64'(wb_err), 64'(0));

        // Randomized evictions with random backpressure and error responses
        for (int r = 0; r < 12; r++) begin
            idx  = $urandom_range(0, NLINES - 1);
            if ($urandom_range(0, 2) != 0)
                fill_line(idx, TAG_SIZE'($urandom()), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            nerr = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
            run(idx, nerr, 2'($urandom_range(1, 3)), "random");
            resp_q.delete();
        end

        repeat (10) @(negedge clk);
        check("left_aw", 64'(exp_aw_q.size()), 64'(0));
        check("left_w", 64'(exp_w_q.size()), 64'(0));
        check("left_dv", 64'(exp_dv_q.size()), 64'(0));
        check("left_done", 64'(exp_err_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "watchdog");
    end

endmodule
